// File: rtl/client_queue_if.sv
// client_queue_if
//   Bundles the sensor inputs, service time and queue status outputs of the
//   client-queue supervisor.
//   Signals:
//     Signal_end   rear (entry) sensor, active-low, idle high
//     Signal_front front (exit) sensor, active-low, idle high
//     Tcount       service time per client, N bits
//     Pcount       clients currently in queue, N bits
//     Wtime        estimated waiting time, 2N+1 bits
//     empty_flag   Pcount == 0
//     Full_flag    Pcount == 2^N-1
//   Modports: master drives sensors/Tcount, slave is the supervisor.
interface client_queue_if #(
    parameter int unsigned N = 3
) ();
    logic             Signal_end;
    logic             Signal_front;
    logic [N-1:0]     Tcount;
    logic [N-1:0]     Pcount;
    logic [2*N:0]     Wtime;
    logic             empty_flag;
    logic             Full_flag;

    modport master (
        output Signal_end,
        output Signal_front,
        output Tcount,
        input  Pcount,
        input  Wtime,
        input  empty_flag,
        input  Full_flag
    );

    modport slave (
        input  Signal_end,
        input  Signal_front,
        input  Tcount,
        output Pcount,
        output Wtime,
        output empty_flag,
        output Full_flag
    );
endinterface

// File: rtl/client_queue.sv
// client_queue
//   Supervisor for a single service line: counts clients between a rear entry
//   sensor and a front exit sensor, saturating at 2^N-1, and reports
//   full/empty flags plus an estimated waiting time Pcount * Tcount.
//   Ports:
//     clk      system clock, all state on the rising edge
//     reset_n  synchronous reset, asserted HIGH (name kept from the codebase)
//     bus      client_queue_if slave: sensors and Tcount in, status out
module client_queue #(
    parameter int unsigned N = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    client_queue_if.slave bus
);
    localparam int unsigned WW  = 2 * N + 1;
    localparam logic [N-1:0] Max = '1;
    localparam logic [N-1:0] One = N'(1);

    // Previous-cycle sensor levels; reset high so a sensor that is already
    // low out of reset still produces one event.
    logic end_q;
    logic front_q;

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    logic arrival;
    logic departure;
    logic empty;
    logic full;

    // Falling-edge detectors: a held-low sensor yields a single event.
    assign arrival   = end_q & ~bus.Signal_end;
    assign departure = front_q & ~bus.Signal_front;

    assign empty = (count_q == '0);
    assign full  = (count_q == Max);

    always_comb begin
        count_d = count_q;
        unique case ({arrival, departure})
            2'b10: if (!full)  count_d = count_q + One;
            2'b01: if (!empty) count_d = count_q - One;
            // Simultaneous events cancel, except on an empty queue where the
            // departure has nobody to remove.
            2'b11: if (empty)  count_d = One;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            end_q   <= 1'b1;
            front_q <= 1'b1;
            count_q <= '0;
        end else begin
            end_q   <= bus.Signal_end;
            front_q <= bus.Signal_front;
            count_q <= count_d;
        end
    end

    assign bus.Pcount     = count_q;
    assign bus.empty_flag = empty;
    assign bus.Full_flag  = full;
    // Live Tcount so a service-time change shows up in the same cycle.
    assign bus.Wtime      = WW'(count_q) * WW'(bus.Tcount);
endmodule

// File: tb/tb_client_queue.sv
module tb_client_queue;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;

    client_queue_if #(.N(N)) bus ();

    client_queue #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    p;
        int    tc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: shortly after each edge, compare every expectation due now.
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: check due cycle %0d, seen at %0d", e.name, e.cyc, cyc);
            end else begin
                chk({e.name, ".Pcount"}, int'(bus.Pcount), e.p);
                chk({e.name, ".Wtime"}, int'(bus.Wtime), e.p * e.tc);
                chk({e.name, ".empty"}, int'(bus.empty_flag), (e.p == 0) ? 1 : 0);
                chk({e.name, ".full"}, int'(bus.Full_flag), (e.p == 7) ? 1 : 0);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and record what the
    // outputs must show after the following rising edge.
    task automatic step(input logic rst, input logic e, input logic f, input int tc,
                        input int exp_p, input string name);
        exp_t x;
        @(negedge clk);
        reset_n          = rst;
        bus.Signal_end   = e;
        bus.Signal_front = f;
        bus.Tcount       = 3'(tc);
        x.cyc  = cyc + 1;
        x.p    = exp_p;
        x.tc   = tc;
        x.name = name;
        exp_q.push_back(x);
    endtask

    initial begin
        reset_n          = 1'b1;
        bus.Signal_end   = 1'b1;
        bus.Signal_front = 1'b1;
        bus.Tcount       = 3'd3;

        step(1, 1, 1, 3, 0, "reset");
        step(0, 1, 1, 3, 0, "idle");
        step(0, 1, 1, 3, 0, "idle2");

        // Two arrivals then one departure.
        step(0, 0, 1, 3, 1, "rear1");
        step(0, 1, 1, 3, 1, "rear1_rel");
        step(0, 0, 1, 3, 2, "rear2");
        step(0, 1, 1, 3, 2, "rear2_rel");
        step(0, 1, 0, 3, 1, "front1");
        step(0, 1, 1, 3, 1, "front1_rel");

        // Simultaneous events at Pcount=2 cancel.
        step(0, 0, 1, 3, 2, "rear3");
        step(0, 1, 1, 3, 2, "rear3_rel");
        step(0, 0, 0, 3, 2, "both_nonzero");
        step(0, 1, 1, 3, 2, "both_nonzero_rel");

        // Simultaneous events at Pcount=0 give 1.
        step(1, 1, 1, 3, 0, "reset2");
        step(0, 0, 0, 3, 1, "both_zero");
        step(0, 1, 1, 3, 1, "both_zero_rel");

        // Fill to capacity, then one dropped arrival.
        step(1, 1, 1, 3, 0, "reset3");
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 1, 3, i, $sformatf("fill%0d", i));
            step(0, 1, 1, 3, i, $sformatf("fill%0d_rel", i));
        end
        step(0, 0, 1, 3, 7, "full_drop");
        step(0, 1, 1, 3, 7, "full_drop_rel");

        // Tcount change reaches Wtime in the same cycle.
        step(0, 1, 1, 5, 7, "tcount5");
        step(0, 1, 1, 7, 7, "tcount7");
        step(0, 1, 1, 0, 7, "tcount0");

        // Drain to empty, then one ignored departure.
        for (int i = 6; i >= 0; i--) begin
            step(0, 1, 0, 3, i, $sformatf("drain%0d", i));
            step(0, 1, 1, 3, i, $sformatf("drain%0d_rel", i));
        end
        step(0, 1, 0, 3, 0, "empty_hold");
        step(0, 1, 1, 3, 0, "empty_hold_rel");

        // Rear held low for five cycles: one increment only.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 3, 1, $sformatf("held%0d", i));
        step(0, 1, 1, 3, 1, "held_rel");

        // Climb to 4, then reset with the rear sensor low.
        for (int i = 2; i <= 4; i++) begin
            step(0, 0, 1, 3, i, $sformatf("climb%0d", i));
            step(0, 1, 1, 3, i, $sformatf("climb%0d_rel", i));
        end
        step(1, 0, 1, 3, 0, "reset_mid");
        step(0, 1, 1, 3, 0, "after_reset");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d checks left pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/client_queue.md
# client_queue

Client-queue supervisor for a single service line. It counts people waiting between a rear entry sensor and a front exit sensor. It saturates at the queue capacity and raises full/empty status flags. It also reports an estimated waiting time, computed as occupancy times a per-client service time. The block is a top-level wrapper around four pieces: two sensor edge detectors, a saturating up/down occupancy counter, and a wait-time multiplier.

## Interface
- N, default 3: counter width; queue capacity is 2^N − 1 clients.

- clk  in  1  single system clock, all state on rising edge.
- reset_n  in  1  reset, synchronous and active-high; the port keeps the codebase name reset_n but is asserted at logic 1.
- Signal_end  in  1  rear (entry) sensor, active-low; idle high.
- Signal_front  in  1  front (exit) sensor, active-low; idle high.
- Tcount  in  N  service time per client, unsigned, any value 0..2^N−1.
- Pcount  out  N  current number of clients in queue, unsigned.
- Wtime  out  2N+1  estimated waiting time, unsigned.
- empty_flag  out  1  high when Pcount == 0.
- Full_flag  out  1  high when Pcount == 2^N − 1.

## Operation
- Each sensor has a sample register holding the previous-cycle level. Both sample registers reset to 1.
- Arrival event: Signal_end sampled low while its sample register holds 1, i.e. a falling edge.
- Departure event: the same falling-edge rule applied to Signal_front.
- A sensor held low for many cycles produces exactly one event. It must return high for at least one rising edge before the next event on that sensor can be detected.
- Occupancy counter update, evaluated at the rising edge in priority order:
  - arrival only, not full: Pcount + 1;
  - arrival only, full: unchanged, the arrival is dropped;
  - departure only, not empty: Pcount − 1;
  - departure only, empty: unchanged;
  - arrival and departure together, 0 < Pcount: unchanged;
  - arrival and departure together, Pcount == 0: becomes 1, the departure is ignored;
  - neither: unchanged.
- No wrap-around in either direction. The counter never exceeds 2^N − 1 and never goes below 0.
- empty_flag = (Pcount == 0), decoded combinationally from the counter register.
- Full_flag = (Pcount == 2^N − 1), decoded combinationally from the counter register.
- Wtime = Pcount × Tcount, zero-extended to 2N+1 bits.
  - Computed combinationally from the registered Pcount and the live Tcount.
  - Wtime is 0 whenever the queue is empty.
- Reset (reset_n = 1 at a rising edge): Pcount 0, empty_flag 1, Full_flag 0, Wtime 0, both sample registers 1.
  - Reset overrides any event in the same cycle.
  - Reset asserted mid-operation clears the queue regardless of the current count.

## Timing
- Event-to-count latency is one edge. Pcount reflects an event after the first rising edge at which the low level is sampled.
- The flags follow Pcount in the same cycle, with no extra latency.
- A change of Tcount is visible on Wtime in the same cycle.
- A sensor low pulse must cover at least one rising edge to register. Shorter pulses may be missed; this is permitted.
- Maximum event rate per sensor is one event every 2 cycles: one cycle low, one cycle high.
- Both outputs and flags are glitch-free relative to clk, since they derive only from registers and Tcount.

## Test plan
- Reset then idle, N=3, Tcount=3 -> Pcount 0, empty_flag 1, Full_flag 0, Wtime 0.
- Two rear pulses, then one front pulse -> Pcount 1, 2, 1; Wtime 3, 6, 3; empty_flag low once the count is nonzero.
- Rear and front low on the same edge with Pcount = 2 -> Pcount stays 2, Wtime 6.
- Rear and front low on the same edge with Pcount = 0 -> Pcount 1, empty_flag 0.
- Seven rear pulses from empty, then an eighth -> Pcount reaches 7 with Full_flag 1 and Wtime 21; the eighth pulse leaves Pcount at 7.
- From full, seven front pulses, then an extra front pulse -> Pcount 6 down to 0 with empty_flag 1 at 0; the extra pulse leaves Pcount at 0.
- Rear sensor held low for 5 cycles -> exactly one increment.
- Assert reset_n = 1 with Pcount = 4 -> Pcount 0, empty_flag 1 on the next edge.
